// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder that time-shares one external 4-bit adder.
// It works LSB nibble first and chains the carry through a register between cycles.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic [4*NIBBLES-1:0]   OpA,
  input  logic [4*NIBBLES-1:0]   OpB,
  input  logic                   CinIn,
  output logic                   Busy,
  output logic                   Done,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   CarryOut,
  output logic [3:0]             AddA,
  output logic [3:0]             AddB,
  output logic                   AddCin,
  input  logic [3:0]             AddS,
  input  logic                   AddCout
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned LAST  = NIBBLES - 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     opa_q, opb_q, acc_q, sum_merge;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             last;

  assign last = (idx_q == IDX_W'(LAST));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = ADD;
      ADD:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final result: accumulator with the top nibble taken straight from the adder
  always_comb begin
    sum_merge = acc_q;
    sum_merge[W-4 +: 4] = AddS;
  end

  // Operand registers drain to zero and the carry register is cleared on exit,
  // so the adder drive is zero outside ADD without any output gating.
  assign AddA   = opa_q[3:0];
  assign AddB   = opb_q[3:0];
  assign AddCin = carry_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      CarryOut <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      Busy    <= (state_d == ADD);
      Done    <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            opa_q   <= OpA;
            opb_q   <= OpB;
            carry_q <= CinIn;
            idx_q   <= '0;
          end
        end
        ADD: begin
          for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) acc_q[4*n +: 4] <= AddS;
          end
          opa_q   <= opa_q >> 4;
          opb_q   <= opb_q >> 4;
          idx_q   <= idx_q + IDX_W'(1);
          carry_q <= AddCout;
          if (last) begin
            Sum      <= sum_merge;
            CarryOut <= AddCout;
            carry_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES = 4, 2 and 1, each instance with a behavioural 4-bit adder.
module tb_nibble_serial_adder;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- NIBBLES = 4 ----------------
  logic        start4, cin4, busy4, done4, co4, addcin4, addcout4;
  logic [15:0] opa4, opb4, sum4;
  logic [3:0]  adda4, addb4, adds4;
  assign {addcout4, adds4} = 5'(adda4) + 5'(addb4) + 5'(addcin4);

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .Start(start4), .OpA(opa4), .OpB(opb4), .CinIn(cin4),
    .Busy(busy4), .Done(done4), .Sum(sum4), .CarryOut(co4),
    .AddA(adda4), .AddB(addb4), .AddCin(addcin4), .AddS(adds4), .AddCout(addcout4)
  );

  // ---------------- NIBBLES = 2 ----------------
  logic       start2, cin2, busy2, done2, co2, addcin2, addcout2;
  logic [7:0] opa2, opb2, sum2;
  logic [3:0] adda2, addb2, adds2;
  assign {addcout2, adds2} = 5'(adda2) + 5'(addb2) + 5'(addcin2);

  nibble_serial_adder #(.NIBBLES(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .Start(start2), .OpA(opa2), .OpB(opb2), .CinIn(cin2),
    .Busy(busy2), .Done(done2), .Sum(sum2), .CarryOut(co2),
    .AddA(adda2), .AddB(addb2), .AddCin(addcin2), .AddS(adds2), .AddCout(addcout2)
  );

  // ---------------- NIBBLES = 1 ----------------
  logic       start1, cin1, busy1, done1, co1, addcin1, addcout1;
  logic [3:0] opa1, opb1, sum1;
  logic [3:0] adda1, addb1, adds1;
  assign {addcout1, adds1} = 5'(adda1) + 5'(addb1) + 5'(addcin1);

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .Start(start1), .OpA(opa1), .OpB(opb1), .CinIn(cin1),
    .Busy(busy1), .Done(done1), .Sum(sum1), .CarryOut(co1),
    .AddA(adda1), .AddB(addb1), .AddCin(addcin1), .AddS(adds1), .AddCout(addcout1)
  );

  // Expected {carry, sum} per accepted request
  logic [16:0] q4[$];
  logic [8:0]  q2[$];
  logic [4:0]  q1[$];
  int          done_cnt4 = 0;

  // Monitors: pop and compare whenever a result is presented
  always @(negedge CLK) begin
    logic [16:0] e4;
    logic [8:0]  e2;
    logic [4:0]  e1;
    if (done4) begin
      done_cnt4++;
      if (q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done4_unexpected: got Done with sum %0h, required no Done", sum4);
      end else begin
        e4 = q4.pop_front();
        chk("sum4", 32'(sum4), 32'(e4[15:0]));
        chk("carry4", 32'(co4), 32'(e4[16]));
      end
    end
    if (done2) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done2_unexpected: got Done with sum %0h, required no Done", sum2);
      end else begin
        e2 = q2.pop_front();
        chk("sum2", 32'(sum2), 32'(e2[7:0]));
        chk("carry2", 32'(co2), 32'(e2[8]));
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done1_unexpected: got Done with sum %0h, required no Done", sum1);
      end else begin
        e1 = q1.pop_front();
        chk("sum1", 32'(sum1), 32'(e1[3:0]));
        chk("carry1", 32'(co1), 32'(e1[4]));
      end
    end
  end

  logic [15:0] prev_sum4 = '0;

  // One NIBBLES=4 request: checks handshake timing, adder drive per cycle and Sum stability.
  // poke bit i raises Start (with OpA=AAAA) in trace cycle i, which must be ignored.
  task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic c, input int poke);
    logic [16:0] exp, m, part;
    exp = {1'b0, a} + {1'b0, b} + 17'(c);
    @(negedge CLK);
    start4 = 1'b1; opa4 = a; opb4 = b; cin4 = c;
    q4.push_back(exp);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i < 4) begin
        m    = (17'(1) << (4 * i)) - 17'(1);
        part = ({1'b0, a} & m) + ({1'b0, b} & m) + 17'(c);
        chk("busy4", 32'(busy4), 32'(1));
        chk("done4_early", 32'(done4), 32'(0));
        chk("adda4", 32'(adda4), 32'(4'(a >> (4 * i))));
        chk("addb4", 32'(addb4), 32'(4'(b >> (4 * i))));
        chk("addcin4", 32'(addcin4), 32'(part[4 * i]));
        chk("sum4_stable", 32'(sum4), 32'(prev_sum4));
      end else if (i == 4) begin
        chk("busy4_done", 32'(busy4), 32'(0));
        chk("done4_pulse", 32'(done4), 32'(1));
        chk("adda4_idle", 32'({adda4, addb4, addcin4}), 32'(0));
      end else begin
        chk("done4_width", 32'(done4), 32'(0));
        chk("busy4_idle", 32'(busy4), 32'(0));
      end
      start4 = poke[i];
      opa4 = poke[i] ? 16'hAAAA : 16'($urandom);
      opb4 = 16'($urandom);
      cin4 = 1'($urandom);
    end
    start4 = 1'b0;
    prev_sum4 = exp[15:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int d0, nd, guard;
    int dt[8];
    logic [7:0] ra, rb;
    logic       rc;

    RST = 1'b1;
    start4 = 0; opa4 = '0; opb4 = '0; cin4 = 0;
    start2 = 0; opa2 = '0; opb2 = '0; cin2 = 0;
    start1 = 0; opa1 = '0; opb1 = '0; cin1 = 0;
    repeat (2) @(negedge CLK);
    chk("rst_busy4", 32'(busy4), 32'(0));
    chk("rst_done4", 32'(done4), 32'(0));
    chk("rst_sum4", 32'({co4, sum4}), 32'(0));
    chk("rst_add4", 32'({adda4, addb4, addcin4}), 32'(0));
    chk("rst_sum2", 32'({co2, sum2, busy2}), 32'(0));
    chk("rst_sum1", 32'({co1, sum1, busy1}), 32'(0));
    RST = 1'b0;

    // NIBBLES=1 boundary: one busy cycle, carry out of the only nibble
    @(negedge CLK);
    start1 = 1'b1; opa1 = 4'hF; opb1 = 4'h1; cin1 = 1'b0;
    q1.push_back(5'h10);
    @(negedge CLK);
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'(1));
    chk("n1_adda", 32'({adda1, addb1}), 32'(8'hF1));
    @(negedge CLK);
    chk("n1_busy_end", 32'(busy1), 32'(0));
    chk("n1_done", 32'(done1), 32'(1));
    @(negedge CLK);
    chk("n1_done_width", 32'(done1), 32'(0));

    // NIBBLES=2 random sweep, with ignored Start noise while busy
    for (int k = 0; k < 500; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      @(negedge CLK);
      start2 = 1'b1; opa2 = ra; opb2 = rb; cin2 = rc;
      q2.push_back({1'b0, ra} + {1'b0, rb} + 9'(rc));
      guard = 0;
      do begin
        @(negedge CLK);
        start2 = 1'($urandom);
        opa2 = 8'($urandom); opb2 = 8'($urandom); cin2 = 1'($urandom);
        guard++;
      end while (!done2 && guard < 8);
      if (!done2) chk("n2_timeout", 32'(done2), 32'(1));
      else chk("n2_latency", 32'(guard), 32'(3));
    end
    start2 = 1'b0;

    // NIBBLES=4 directed cases
    run_op4(16'h1234, 16'h4321, 1'b0, 0);
    run_op4(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op4(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op4(16'h8000, 16'h8001, 1'b1, 0);

    d0 = done_cnt4;
    run_op4(16'h0001, 16'h0001, 1'b0, 32'b10010);
    repeat (8) @(negedge CLK);
    chk("start_while_busy_dones", 32'(done_cnt4 - d0), 32'(1));

    // Start held high: one accepted request per six cycles
    @(negedge CLK);
    start4 = 1'b1; opa4 = 16'h0F0F; opb4 = 16'h1111; cin4 = 1'b0;
    repeat (3) q4.push_back(17'h02020);
    nd = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      if (i == 13) start4 = 1'b0;
      if (done4 && nd < 8) begin
        dt[nd] = i;
        nd++;
      end
    end
    chk("held_done_count", 32'(nd), 32'(3));
    chk("held_first_done", 32'(dt[0]), 32'(5));
    chk("held_gap1", 32'(dt[1] - dt[0]), 32'(6));
    chk("held_gap2", 32'(dt[2] - dt[1]), 32'(6));
    prev_sum4 = 16'h2020;

    // Reset during the third busy cycle abandons the add
    @(negedge CLK);
    start4 = 1'b1; opa4 = 16'h1111; opb4 = 16'h2222; cin4 = 1'b0;
    q4.push_back(17'h03333);
    @(negedge CLK);
    start4 = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", 32'(busy4), 32'(0));
    chk("midrst_done", 32'(done4), 32'(0));
    chk("midrst_sum", 32'({co4, sum4}), 32'(0));
    chk("midrst_add", 32'({adda4, addb4, addcin4}), 32'(0));
    RST = 1'b0;
    if (q4.size() > 0) void'(q4.pop_back());
    d0 = done_cnt4;
    repeat (10) @(negedge CLK);
    chk("midrst_no_done", 32'(done_cnt4 - d0), 32'(0));
    prev_sum4 = '0;
    run_op4(16'h1111, 16'h2222, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), 0);
    end

    repeat (5) @(negedge CLK);
    chk("q4_drained", 32'(q4.size()), 32'(0));
    chk("q2_drained", 32'(q2.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequencing controller that performs a wide addition (default 16-bit) over several clock cycles using one external 4-bit combinational adder (fouraddr). It sits directly around the adder: it feeds A/B/Cin one nibble per cycle, LSB nibble first, and consumes S/Cout. It chains carries through a register and assembles the wide Sum. Start/Busy/Done handshake faces the requesting logic.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
Start  input  1  request; sampled only in IDLE
OpA  input  W  operand A; sampled with Start
OpB  input  W  operand B; sampled with Start
CinIn  input  1  carry-in of the wide add; sampled with Start
Busy  output  1  high while in ADD
Done  output  1  one-cycle pulse; result valid
Sum  output  W  registered wide sum; held until the next result
CarryOut  output  1  registered carry out of the top nibble
AddA  output  4  to fouraddr A
AddB  output  4  to fouraddr B
AddCin  output  1  to fouraddr Cin
AddS  input  4  from fouraddr S
AddCout  input  1  from fouraddr Cout

Behaviour:
- Clocking and reset: single clock CLK; RST is synchronous and active-high.
- Reset: state=IDLE; Busy, Done, Sum, CarryOut, AddA, AddB, AddCin all 0; internal shift registers, carry register, accumulator and nibble index cleared.
- Reset mid-operation: the in-flight add is abandoned. Done is not pulsed, and Sum/CarryOut return to 0 on that edge.
- FSM states: IDLE, ADD, DONE.
- IDLE, Start=1 at an edge:
  - latch OpA/OpB into operand shift registers;
  - carry reg <= CinIn; idx <= 0; go ADD.
- IDLE, Start=0: stay in IDLE.
- ADD, combinational outputs: AddA = opA_sh[3:0], AddB = opB_sh[3:0], AddCin = carry reg. The adder path is combinational within the cycle.
- ADD, each edge:
  - accumulator nibble[idx] <= AddS;
  - carry reg <= AddCout;
  - shift both operand registers right by 4; idx++.
- ADD, exit: at the edge where idx==NIBBLES-1, go DONE.
  - Sum <= accumulator with the final nibble merged (AddS in the top nibble).
  - CarryOut <= AddCout.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
- Start handling outside IDLE: Start in ADD or DONE is ignored, not queued.
- Adder drive outside ADD: AddA, AddB and AddCin are 0 in IDLE and DONE.
- Latency: with Start sampled at edge k, Busy is high during cycles k+1..k+NIBBLES, and Done is high in the cycle after edge k+NIBBLES. For NIBBLES=4 that is 4 busy cycles, then Done.
- Next request: the earliest next Start is accepted at the edge that leaves DONE+1, i.e. back-to-back throughput is one op per NIBBLES+2 cycles.
- Output stability: Sum and CarryOut change only on the DONE-entry edge or reset, so they are stable while Busy.
- Arithmetic: unsigned modulo 2^W, with CarryOut = bit W of OpA+OpB+CinIn. No overflow flag.
- Input timing: operand inputs may change freely after the Start edge; the latched copies are used.

Test Plan:
- Basic add: reset 2 cycles, then Start with OpA=16'h1234, OpB=16'h4321, CinIn=0 -> Busy 4 cycles, Done pulse 1 cycle, Sum=16'h5555, CarryOut=0. AddA sequence 4,3,2,1 and AddB 1,2,3,4 on consecutive cycles.
- Full carry ripple: OpA=16'hFFFF, OpB=16'h0001, CinIn=0 -> Sum=16'h0000, CarryOut=1; AddCin sequence 0,1,1,1. Repeat with OpA=16'hFFFF, OpB=16'h0000, CinIn=1 -> Sum=16'h0000, CarryOut=1.
- Mixed carry: OpA=16'h8000, OpB=16'h8001, CinIn=1 -> Sum=16'h0002, CarryOut=1.
- Start while busy: issue 16'h0001+16'h0001, then pulse Start with OpA=16'hAAAA during the 2nd Busy cycle.
  - Required: only one Done, Sum=16'h0002.
  - Start asserted during the Done cycle is also ignored.
  - Start held high continuously gives Done every 6 cycles.
- Reset mid-op: start 16'h1111+16'h2222, assert RST during the 3rd Busy cycle.
  - Next edge: Busy=0, Sum=0, CarryOut=0, AddA/AddB/AddCin=0.
  - No Done pulse for 10 cycles.
  - A fresh 16'h1111+16'h2222 then yields 16'h3333.
- Parameter sweep: NIBBLES=1 with OpA=4'hF, OpB=4'h1 -> Busy 1 cycle, Sum=4'h0, CarryOut=1. NIBBLES=2 random 500 ops checked against a behavioural +.
